riscv_id_ex_stage: RTL and testbench

Decode/issue stage that sits directly upstream of the 32-bit execute ALU and feeds it. It decodes an instruction into the ALU's 7-bit operation code and selects forwarded operands. It latches the decoded operation, operands and destination into a single-entry pipeline register with a valid/ready handshake. It also supports flush and counts back-pressure cycles.

---
 rtl/riscv_id_ex_stage_if.sv | 44 ++++
 rtl/riscv_id_ex_stage.sv | 137 +++++++++++++
 tb/tb_riscv_id_ex_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/riscv_id_ex_stage_if.sv
// Handshake and data bundle between the decode/issue stage and its surroundings.
// The stage uses the slave modport; the upstream/ALU side (or a bench) uses master.
interface riscv_id_ex_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             exmem_wen;
    logic [4:0]       exmem_rd;
    logic [WIDTH-1:0] exmem_data;
    logic             memwb_wen;
    logic [4:0]       memwb_rd;
    logic [WIDTH-1:0] memwb_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [6:0]       ALUOp;
    logic [4:0]       rd;
    logic             wen;
    logic             illegal;
    logic [CNT_W-1:0] stall_cycles;

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data,
        input  exmem_wen, exmem_rd, exmem_data,
        input  memwb_wen, memwb_rd, memwb_data,
        input  flush, out_ready,
        output in_ready, out_valid, A, B, ALUOp, rd, wen, illegal, stall_cycles
    );

    modport master (
        output in_valid, instr, rs1_data, rs2_data,
        output exmem_wen, exmem_rd, exmem_data,
        output memwb_wen, memwb_rd, memwb_data,
        output flush, out_ready,
        input  in_ready, out_valid, A, B, ALUOp, rd, wen, illegal, stall_cycles
    );
endinterface

// File: rtl/riscv_id_ex_stage.sv
// RV32 decode/issue stage: decodes into the ALU op code, forwards operands and
// holds the result in a single-entry valid/ready pipeline register.
module riscv_id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    riscv_id_ex_stage_if.slave  bus
);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rs_idx  [2];
    logic [WIDTH-1:0] rf_data [2];
    logic [WIDTH-1:0] fwd_data[2];
    logic [WIDTH-1:0] imm_ext;

    logic             valid_reg;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [6:0]       op_reg, op_next;
    logic [4:0]       rd_reg;
    logic             wen_reg, wen_next;
    logic             illegal_reg, illegal_next;
    logic [CNT_W-1:0] stall_reg;
    logic             capture;

    assign opcode     = bus.instr[6:0];
    assign funct3     = bus.instr[14:12];
    assign funct7     = bus.instr[31:25];
    assign rs_idx[0]  = bus.instr[19:15];
    assign rs_idx[1]  = bus.instr[24:20];
    assign rf_data[0] = bus.rs1_data;
    assign rf_data[1] = bus.rs2_data;
    assign imm_ext    = {{(WIDTH-12){bus.instr[31]}}, bus.instr[31:20]};

    // x0 reads as zero; EX/MEM wins over MEM/WB when both target the same register.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_data[gi] =
                (rs_idx[gi] == 5'd0)                              ? '0 :
                (bus.exmem_wen && (bus.exmem_rd == rs_idx[gi]))   ? bus.exmem_data :
                (bus.memwb_wen && (bus.memwb_rd == rs_idx[gi]))   ? bus.memwb_data :
                                                                    rf_data[gi];
        end
    endgenerate

    always_comb begin
        op_next      = 7'b1111111;
        illegal_next = 1'b1;
        a_next       = '0;
        b_next       = '0;
        if (opcode == OP_R) begin
            illegal_next = 1'b0;
            unique case ({funct7, funct3})
                {7'b0000000, 3'b000}: op_next = 7'b0000000;
                {7'b0100000, 3'b000}: op_next = 7'b0000001;
                {7'b0000001, 3'b000}: op_next = 7'b0000010;
                {7'b0000000, 3'b100}: op_next = 7'b0000110;
                {7'b0000000, 3'b110}: op_next = 7'b0000101;
                {7'b0000000, 3'b111}: op_next = 7'b0000100;
                default: begin
                    op_next      = 7'b1111111;
                    illegal_next = 1'b1;
                end
            endcase
            if (!illegal_next) begin
                a_next = fwd_data[0];
                b_next = fwd_data[1];
            end
        end else if (opcode == OP_I) begin
            illegal_next = 1'b0;
            unique case (funct3)
                3'b000:  op_next = 7'b0000000;
                3'b100:  op_next = 7'b0000110;
                3'b110:  op_next = 7'b0000101;
                3'b111:  op_next = 7'b0000100;
                default: begin
                    op_next      = 7'b1111111;
                    illegal_next = 1'b1;
                end
            endcase
            if (!illegal_next) begin
                a_next = fwd_data[0];
                b_next = imm_ext;
            end
        end
        wen_next = !illegal_next && (bus.instr[11:7] != 5'd0);
    end

    // out_ready only reaches in_ready; the register outputs never see it combinationally.
    assign bus.in_ready = !valid_reg || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg   <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= '0;
            rd_reg      <= '0;
            wen_reg     <= 1'b0;
            illegal_reg <= 1'b0;
            stall_reg   <= '0;
        end else begin
            if (bus.flush) begin
                valid_reg <= 1'b0;
            end else if (capture) begin
                valid_reg   <= 1'b1;
                a_reg       <= a_next;
                b_reg       <= b_next;
                op_reg      <= op_next;
                rd_reg      <= bus.instr[11:7];
                wen_reg     <= wen_next;
                illegal_reg <= illegal_next;
            end else if (bus.out_ready) begin
                valid_reg <= 1'b0;
            end
            if (valid_reg && !bus.out_ready && !bus.flush && (stall_reg != '1)) begin
                stall_reg <= stall_reg + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid    = valid_reg;
    assign bus.A            = a_reg;
    assign bus.B            = b_reg;
    assign bus.ALUOp        = op_reg;
    assign bus.rd           = rd_reg;
    assign bus.wen          = wen_reg;
    assign bus.illegal      = illegal_reg;
    assign bus.stall_cycles = stall_reg;
endmodule

// File: tb/tb_riscv_id_ex_stage.sv
// Directed-vector bench for riscv_id_ex_stage with hand-computed expectations.
module tb_riscv_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    riscv_id_ex_stage_if #(.WIDTH(32), .CNT_W(16)) bus ();

    riscv_id_ex_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [6:0] op, input logic [4:0] rdx, input logic w,
                              input logic ill);
        check({tag, ".valid"},   32'(bus.out_valid), 32'd1);
        check({tag, ".A"},       bus.A, a);
        check({tag, ".B"},       bus.B, b);
        check({tag, ".ALUOp"},   32'(bus.ALUOp), 32'(op));
        check({tag, ".rd"},      32'(bus.rd), 32'(rdx));
        check({tag, ".wen"},     32'(bus.wen), 32'(w));
        check({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
    endtask

    task automatic expect_reset(input string tag);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".A"},     bus.A, 32'd0);
        check({tag, ".B"},     bus.B, 32'd0);
        check({tag, ".ALUOp"}, 32'(bus.ALUOp), 32'd0);
        check({tag, ".rd"},    32'(bus.rd), 32'd0);
        check({tag, ".wen"},   32'(bus.wen), 32'd0);
        check({tag, ".ill"},   32'(bus.illegal), 32'd0);
        check({tag, ".stall"}, 32'(bus.stall_cycles), 32'd0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.instr      = 32'd0;
        bus.rs1_data   = 32'd0;
        bus.rs2_data   = 32'd0;
        bus.exmem_wen  = 1'b0;
        bus.exmem_rd   = 5'd0;
        bus.exmem_data = 32'd0;
        bus.memwb_wen  = 1'b0;
        bus.memwb_rd   = 5'd0;
        bus.memwb_data = 32'd0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;

        tick();
        tick();
        expect_reset("rst_init");
        check("rst_init.in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b1;

        // ADD x3,x1,x2 with plain register-file operands
        bus.out_ready = 1'b1;
        send(32'h002081B3, 32'd5, 32'd7);
        tick();
        bus.in_valid = 1'b0;
        expect_out("add", 32'd5, 32'd7, 7'b0000000, 5'd3, 1'b1, 1'b0);
        tick();
        check("drain.valid", 32'(bus.out_valid), 32'd0);

        // ADDI x4,x1,-1 with both stages matching rs1: EX/MEM wins
        bus.exmem_wen = 1'b1; bus.exmem_rd = 5'd1; bus.exmem_data = 32'h10;
        bus.memwb_wen = 1'b1; bus.memwb_rd = 5'd1; bus.memwb_data = 32'h20;
        send(32'hFFF08213, 32'd5, 32'd0);
        tick();
        expect_out("addi_exmem", 32'h10, 32'hFFFFFFFF, 7'b0000000, 5'd4, 1'b1, 1'b0);
        bus.exmem_wen = 1'b0;
        tick();
        expect_out("addi_memwb", 32'h20, 32'hFFFFFFFF, 7'b0000000, 5'd4, 1'b1, 1'b0);
        bus.exmem_wen = 1'b1;
        send(32'hFFF00213, 32'd5, 32'd0);
        tick();
        expect_out("addi_x0", 32'd0, 32'hFFFFFFFF, 7'b0000000, 5'd4, 1'b1, 1'b0);
        bus.exmem_wen = 1'b0;
        bus.memwb_wen = 1'b0;

        // SUB captured, then three cycles of back-pressure with a waiting ADD
        send(32'h402081B3, 32'd9, 32'd4);
        tick();
        expect_out("sub", 32'd9, 32'd4, 7'b0000001, 5'd3, 1'b1, 1'b0);
        bus.out_ready = 1'b0;
        send(32'h002081B3, 32'd1, 32'd2);
        #1;
        check("hold.in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("hold%0d", i), 32'd9, 32'd4, 7'b0000001, 5'd3, 1'b1, 1'b0);
        end
        check("hold.stall", 32'(bus.stall_cycles), 32'd3);
        bus.out_ready = 1'b1;
        #1;
        check("release.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        expect_out("b2b_add", 32'd1, 32'd2, 7'b0000000, 5'd3, 1'b1, 1'b0);
        check("b2b.stall", 32'(bus.stall_cycles), 32'd3);

        // Flush with a held entry and a stalled output: nothing captured, no stall count
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        send(32'h0020C2B3, 32'd3, 32'd6);
        tick();
        check("flush.valid", 32'(bus.out_valid), 32'd0);
        check("flush.stall", 32'(bus.stall_cycles), 32'd3);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("post_flush.valid", 32'(bus.out_valid), 32'd0);

        // Unsupported opcode, then MUL x5,x6,x7
        send(32'h0000007F, 32'hAA, 32'hBB);
        tick();
        expect_out("illegal", 32'd0, 32'd0, 7'b1111111, 5'd0, 1'b0, 1'b1);
        send(32'h027302B3, 32'h11, 32'h22);
        tick();
        expect_out("mul", 32'h11, 32'h22, 7'b0000010, 5'd5, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a hold
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("prereset.valid", 32'(bus.out_valid), 32'd1);
        check("prereset.stall", 32'(bus.stall_cycles), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        expect_reset("rst_async");
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
